// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I core: forwarding selects plus
// load-use stall and branch flush, driven from a private E/M/W shadow pipe.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   rs1_d, rs2_d, rd_d   Decode-stage register indices
//   reg_write_d          Decode-stage instruction writes rd
//   mem_to_reg_d         Decode-stage instruction is a load
//   pc_src_e             branch/jump resolved taken in Execute
//   forward_a_e/b_e      00 regfile, 01 WB result, 10 MEM result
//   stall_f, stall_d     hold PC and IF/ID
//   flush_d, flush_e     clear IF/ID and ID/EX
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic                      mem_to_reg_d,
  input  logic                      pc_src_e,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e
);

  localparam int W = REG_ADDR_WIDTH;

  logic [W-1:0] rs1_e;
  logic [W-1:0] rs2_e;
  logic [W-1:0] rd_e;
  logic         reg_write_e;
  logic         mem_to_reg_e;
  logic [W-1:0] rd_m;
  logic         reg_write_m;
  logic [W-1:0] rd_w;
  logic         reg_write_w;
  logic         lw_stall;

  // No enable: a stalled D is held upstream and the E bubble
  // comes from flush_e.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
    end else begin
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      if (flush_e) begin
        rs1_e        <= '0;
        rs2_e        <= '0;
        rd_e         <= '0;
        reg_write_e  <= 1'b0;
        mem_to_reg_e <= 1'b0;
      end else begin
        rs1_e        <= rs1_d;
        rs2_e        <= rs2_d;
        rd_e         <= rd_d;
        reg_write_e  <= reg_write_d;
        mem_to_reg_e <= mem_to_reg_d;
      end
    end
  end

  // MEM beats WB: it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(
    input logic [W-1:0] rs,
    input logic         wm,
    input logic [W-1:0] rdm,
    input logic         ww,
    input logic [W-1:0] rdw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wm && (rdm != '0) && (rdm == rs))
      sel = 2'b10;
    else if (ww && (rdw != '0) && (rdw == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m,
                               reg_write_w, rd_w);
  assign forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m,
                               reg_write_w, rd_w);

  // rs fields are compared even when unused: conservative.
  assign lw_stall = mem_to_reg_e && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // A taken branch discards D anyway, so it overrides the stall.
  assign stall_f = lw_stall && !pc_src_e;
  assign stall_d = lw_stall && !pc_src_e;
  assign flush_d = pc_src_e;
  assign flush_e = lw_stall || pc_src_e;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with an in-bench instruction-slot model
// and hand-computed literal checks at the interesting cycles.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_d;
  logic       reg_write_d;
  logic       mem_to_reg_d;
  logic       pc_src_e;
  logic [1:0] forward_a_e;
  logic [1:0] forward_b_e;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  ins_t pe = '0;
  ins_t pm = '0;
  ins_t pw = '0;

  localparam ins_t NOP = '0;

  hazard_unit #(.REG_ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .reg_write_d  (reg_write_d),
    .mem_to_reg_d (mem_to_reg_d),
    .pc_src_e     (pc_src_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int a, input int b, input int d,
                              input bit w, input bit l);
    ins_t i;
    i.rs1 = 5'(a);
    i.rs2 = 5'(b);
    i.rd  = 5'(d);
    i.rw  = w;
    i.ld  = l;
    return i;
  endfunction

  // Which pipeline slot, if any, supplies the newest value of rs.
  function automatic logic [1:0] src_of(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (pm.rw && pm.rd == rs) return 2'b10;
    if (pw.rw && pw.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      logic lu;
      logic [3:0] ctl;
      lu = pe.ld && (pe.rd != 0) &&
           (pe.rd == rs1_d || pe.rd == rs2_d);
      ctl = {lu && !pc_src_e, lu && !pc_src_e,
             pc_src_e, lu || pc_src_e};
      chk("model_fwd_a", {2'b00, forward_a_e},
          {2'b00, src_of(pe.rs1)});
      chk("model_fwd_b", {2'b00, forward_b_e},
          {2'b00, src_of(pe.rs2)});
      chk("model_ctl", {stall_f, stall_d, flush_d, flush_e}, ctl);
      if (rst) begin
        pe = NOP;
        pm = NOP;
        pw = NOP;
      end else begin
        pw = pm;
        pm = pe;
        pe = ctl[0] ? NOP :
             mk(rs1_d, rs2_d, rd_d, reg_write_d, mem_to_reg_d);
      end
    end
  end

  task automatic drive(input ins_t i, input logic pcs, input logic r);
    @(posedge clk);
    #1;
    rs1_d        = i.rs1;
    rs2_d        = i.rs2;
    rd_d         = i.rd;
    reg_write_d  = i.rw;
    mem_to_reg_d = i.ld;
    pc_src_e     = pcs;
    rst          = r;
    #2;
  endtask

  function automatic logic [3:0] ctl_now();
    return {stall_f, stall_d, flush_d, flush_e};
  endfunction

  ins_t lw7;
  ins_t use7;

  initial begin
    rst          = 1'b1;
    rs1_d        = 5'($urandom_range(31));
    rs2_d        = 5'($urandom_range(31));
    rd_d         = 5'($urandom_range(31));
    reg_write_d  = 1'b1;
    mem_to_reg_d = 1'b1;
    pc_src_e     = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b1;

    // Reset held with random D inputs
    drive(mk($urandom_range(31), $urandom_range(31),
             $urandom_range(31), 1, 1), 0, 1);
    chk("rst_ctl", ctl_now(), 4'b0000);
    chk("rst_fwd", {forward_a_e, forward_b_e}, 4'b0000);
    drive(NOP, 0, 0);
    chk("post_rst_fwd", {forward_a_e, forward_b_e}, 4'b0000);

    // ALU chain: back-to-back -> MEM forward on both operands
    drive(mk(1, 2, 5, 1, 0), 0, 0);
    drive(mk(5, 5, 6, 1, 0), 0, 0);
    drive(NOP, 0, 0);
    chk("alu_mem_fwd", {forward_a_e, forward_b_e}, 4'b1010);

    // One NOP gap -> WB forward
    drive(mk(1, 2, 5, 1, 0), 0, 0);
    drive(NOP, 0, 0);
    drive(mk(5, 5, 6, 1, 0), 0, 0);
    drive(NOP, 0, 0);
    chk("alu_wb_fwd", {forward_a_e, forward_b_e}, 4'b0101);

    // x5 in both M and W: MEM wins
    drive(mk(1, 2, 5, 1, 0), 0, 0);
    drive(mk(3, 4, 5, 1, 0), 0, 0);
    drive(mk(5, 0, 10, 1, 0), 0, 0);
    drive(NOP, 0, 0);
    chk("double_prio", {forward_a_e, forward_b_e}, 4'b1000);

    // x0 is never forwarded, load to x0 never stalls
    drive(mk(1, 2, 0, 1, 0), 0, 0);
    drive(mk(0, 0, 11, 1, 0), 0, 0);
    drive(NOP, 0, 0);
    chk("x0_fwd", {forward_a_e, forward_b_e}, 4'b0000);
    drive(mk(1, 0, 0, 1, 1), 0, 0);
    drive(mk(0, 0, 12, 1, 0), 0, 0);
    chk("x0_load_nostall", ctl_now(), 4'b0000);

    // Load-use: one stall cycle, then WB forward
    lw7  = mk(1, 0, 7, 1, 1);
    use7 = mk(7, 1, 8, 1, 0);
    drive(lw7, 0, 0);
    drive(use7, 0, 0);
    chk("lu_stall", ctl_now(), 4'b1101);
    drive(use7, 0, 0);
    chk("lu_released", ctl_now(), 4'b0000);
    drive(NOP, 0, 0);
    chk("lu_wb_fwd", {forward_a_e, forward_b_e}, 4'b0100);

    // Taken branch coincident with load-use: flush wins
    drive(lw7, 0, 0);
    drive(use7, 1, 0);
    chk("br_vs_lu", ctl_now(), 4'b0011);
    drive(mk(7, 7, 9, 1, 0), 0, 0);
    chk("br_bubble_fwd", {forward_a_e, forward_b_e}, 4'b0000);
    chk("br_bubble_ctl", ctl_now(), 4'b0000);

    // Back-to-back load-use chain
    drive(lw7, 0, 0);
    drive(mk(7, 0, 9, 1, 1), 0, 0);
    chk("chain_stall1", ctl_now(), 4'b1101);
    drive(mk(7, 0, 9, 1, 1), 0, 0);
    drive(mk(0, 9, 10, 1, 0), 0, 0);
    chk("chain_stall2", ctl_now(), 4'b1101);
    drive(mk(0, 9, 10, 1, 0), 0, 0);
    drive(NOP, 0, 0);

    // Reset arriving mid-stall ends the stall
    drive(lw7, 0, 0);
    drive(use7, 0, 1);
    chk("rst_midstall_on", ctl_now(), 4'b1101);
    drive(use7, 0, 0);
    chk("rst_midstall_off", ctl_now(), 4'b0000);

    // Mixed traffic over a small register range, model-checked
    for (int n = 0; n < 60; n++) begin
      drive(mk($urandom_range(3), $urandom_range(3),
               $urandom_range(3), $urandom_range(1),
               $urandom_range(1)),
            ($urandom_range(7) == 0), 1'b0);
    end

    drive(NOP, 0, 0);
    @(posedge clk);
    #1;
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
